vending_machine_param: RTL and testbench
========================================

# vending_machine_param

Parametrised successor to the single-price vending controller. It accepts coins on the 2-bit `coin` code, accumulates credit and asserts `Z` for one cycle when credit reaches `PRICE`. Any excess credit, or the whole credit on `cancel`, is returned as change one unit at a time through a request/acknowledge handshake with the coin-return mechanism. It sits between the coin validator, the product dispenser and the change hopper.

## Interface
- `PRICE`, 15, product price in value units.
- `COIN1_VAL`, 5, value of coin code 2'b01.
- `COIN2_VAL`, 10, value of coin code 2'b10.
- `COIN3_VAL`, 25, value of coin code 2'b11.
- `CHG_UNIT`, 5, value returned per change handshake. `PRICE` and every `COINx_VAL` must be multiples of it.
- `CREDIT_W`, 6, credit width. Must satisfy 2^CREDIT_W > PRICE-1+max(COINx_VAL).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `coin` input 2: 00 means no coin; 01, 10 and 11 mean coin 1, 2 and 3. Valid for one cycle per coin.
- `cancel` input 1: refund request, level-sampled.
- `chg_ack` input 1: hopper has released one `CHG_UNIT`.
- `Z` output 1: vend pulse, one cycle.
- `change_given` output 1: one-cycle pulse when a non-zero change or refund completes.
- `chg_req` output 1: change pending, one unit requested.
- `coin_reject` output 1: one-cycle pulse, inserted coin not accepted.
- `busy` output 1: high in VEND and CHANGE.
- `credit` output CREDIT_W: current credit or remaining change.

## Operation
- Reset (`rst`=0) forces state IDLE and sets `credit`, `Z`, `change_given`, `chg_req`, `coin_reject` and `busy` to 0. It acts immediately and regardless of `clk`, including mid-CHANGE. Any pending change is discarded.
- States:
  - IDLE: `credit` is 0.
  - COLLECT: 0 < `credit` < `PRICE`.
  - VEND: single cycle.
  - CHANGE: change is being returned.
- IDLE/COLLECT with a non-zero `coin`:
  - On the clock edge, `credit` becomes credit+COINx_VAL.
  - If the new credit ≥ `PRICE`, the next state is VEND. Otherwise it is COLLECT.
- VEND:
  - `Z` is 1 and `credit` becomes credit−PRICE.
  - The next state is CHANGE if the remainder is greater than 0, else IDLE.
- CHANGE:
  - `chg_req` is 1.
  - Each edge with `chg_ack`=1 subtracts `CHG_UNIT` from `credit`.
  - The ack that brings `credit` to 0 moves the state to IDLE and pulses `change_given` in the following cycle.
  - `chg_ack` while `chg_req`=0 is ignored.
- `cancel` in COLLECT moves to CHANGE with `credit` unchanged as the refund, and no `Z`. `cancel` in IDLE, VEND or CHANGE is ignored.
- `cancel` and `coin` on the same edge in COLLECT or IDLE: `cancel` wins. The coin is not credited and `coin_reject` pulses.
- A coin in VEND or CHANGE is not credited, `coin_reject` pulses and `credit` is unaffected.
- Arithmetic is unsigned CREDIT_W-bit. The parameter constraint guarantees no overflow, and the design contains no saturation logic.

## Timing
- All outputs are registered. Nothing is combinational from the inputs.
- Coin to vend:
  - Coin sampled at edge N.
  - `credit` is updated after edge N.
  - If the price is reached, the state is VEND and `Z`=1 during cycle N+1.
- VEND always lasts exactly one cycle. `busy` is high from cycle N+1 until the state returns to IDLE.
- `chg_req` rises in the cycle after VEND, or in the cycle after the `cancel` edge. It holds indefinitely while `chg_ack`=0.
- Change throughput is at most one unit per cycle, with `chg_ack` held high.
- `change_given` is high in the single cycle after the final ack edge. `chg_req` is 0 in that same cycle.
- `coin_reject` is high in the cycle after the rejected coin edge.

## Test plan
All scenarios use default parameters.
- Reset, then `coin`=01 at three edges → `credit` goes 5, 10, 15. `Z`=1 for one cycle after the third edge. `change_given` stays 0. `credit` returns to 0 and `busy` to 0.
- `coin`=11 once → `Z` pulse, then CHANGE with `credit`=10 and `chg_req`=1. `chg_ack` high for 2 cycles → `credit` goes 5, 0. `change_given` pulses once and `chg_req` drops.
- `coin`=10, then `coin`=10 → `credit`=20, `Z` pulse, 5 change. One ack → `change_given`.
- `coin`=01, then `cancel`=1 → no `Z`, `chg_req`=1 with `credit`=5. One ack → `change_given`. `cancel` in IDLE → no effect.
- In CHANGE with `chg_ack`=0, apply `coin`=10 → `coin_reject` pulse, `credit` unchanged, and `chg_req` stays high for at least 10 cycles.
- `cancel` and `coin`=01 on the same edge in COLLECT → `coin_reject` pulse and refund equals the prior credit. Drive `rst`=0 mid-CHANGE between clock edges → all outputs 0 immediately. After release, three `coin`=01 produce a normal vend.

Source files
------------

// File: rtl/vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_param
// Purpose  : Parametrised coin vending controller with unit-by-unit change
//            return through a request/acknowledge handshake to the hopper.
// Revision : 1.0 - initial release
// ============================================================================
module vending_machine_param #(
    parameter int PRICE     = 15,
    parameter int COIN1_VAL = 5,
    parameter int COIN2_VAL = 10,
    parameter int COIN3_VAL = 25,
    parameter int CHG_UNIT  = 5,
    parameter int CREDIT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                chg_ack,
    output logic                Z,
    output logic                change_given,
    output logic                chg_req,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] C_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C_COIN1 = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] C_COIN2 = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] C_COIN3 = CREDIT_W'(COIN3_VAL);
    localparam logic [CREDIT_W-1:0] C_UNIT  = CREDIT_W'(CHG_UNIT);

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                z_q;
    logic                change_given_q;
    logic                chg_req_q;
    logic                coin_reject_q;
    logic                busy_q;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_coin_present;

    always_comb begin
        w_coin_val = '0;
        case (coin)
            2'b01:   w_coin_val = C_COIN1;
            2'b10:   w_coin_val = C_COIN2;
            2'b11:   w_coin_val = C_COIN3;
            default: w_coin_val = '0;
        endcase
    end

    assign w_sum          = credit_q + w_coin_val;
    assign w_coin_present = (coin != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            z_q            <= 1'b0;
            change_given_q <= 1'b0;
            chg_req_q      <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            z_q            <= 1'b0;
            change_given_q <= 1'b0;
            // A coin is refused while busy, or when it coincides with cancel
            coin_reject_q  <= w_coin_present &&
                              (cancel || state_q == S_VEND || state_q == S_CHANGE);
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (cancel && state_q == S_COLLECT) begin
                        state_q   <= S_CHANGE;
                        chg_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (w_coin_present && !cancel) begin
                        credit_q <= w_sum;
                        if (w_sum >= C_PRICE) begin
                            state_q <= S_VEND;
                            z_q     <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_VEND: begin
                    credit_q <= credit_q - C_PRICE;
                    if (credit_q != C_PRICE) begin
                        state_q   <= S_CHANGE;
                        chg_req_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_CHANGE: begin
                    if (chg_ack) begin
                        credit_q <= credit_q - C_UNIT;
                        if (credit_q == C_UNIT) begin
                            state_q        <= S_IDLE;
                            chg_req_q      <= 1'b0;
                            busy_q         <= 1'b0;
                            change_given_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Z            = z_q;
    assign change_given = change_given_q;
    assign chg_req      = chg_req_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;
    assign credit       = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_param
// Purpose  : Directed and randomized self-checking bench for the vending FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_machine_param;

    localparam int PRICE = 15;
    localparam int UNIT  = 5;
    localparam int CW    = 6;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic [1:0]    coin    = 2'b00;
    logic          cancel  = 1'b0;
    logic          chg_ack = 1'b0;
    logic          Z, change_given, chg_req, coin_reject, busy;
    logic [CW-1:0] credit;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: credit as plain integer plus "vending"/"refunding" flags
    int m_credit;
    bit m_vend, m_chg, e_z, e_cg, e_rej;
    int coin_tab [4] = '{0, 5, 10, 25};

    vending_machine_param dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .cancel       (cancel),
        .chg_ack      (chg_ack),
        .Z            (Z),
        .change_given (change_given),
        .chg_req      (chg_req),
        .coin_reject  (coin_reject),
        .busy         (busy),
        .credit       (credit)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] dut_vec();
        return {Z, change_given, chg_req, coin_reject, busy, credit};
    endfunction

    function automatic logic [10:0] model_vec();
        return {e_z, e_cg, m_chg, e_rej, (m_vend || m_chg), CW'(m_credit)};
    endfunction

    task automatic model_reset();
        m_credit = 0; m_vend = 0; m_chg = 0; e_z = 0; e_cg = 0; e_rej = 0;
    endtask

    task automatic model_step(input logic [1:0] c, input logic cn, input logic a);
        e_z = 0; e_cg = 0; e_rej = 0;
        if (m_vend) begin
            m_credit = m_credit - PRICE;
            m_vend   = 0;
            m_chg    = (m_credit > 0);
            e_rej    = (c != 0);
        end else if (m_chg) begin
            e_rej = (c != 0);
            if (a) begin
                m_credit = m_credit - UNIT;
                if (m_credit == 0) begin
                    m_chg = 0;
                    e_cg  = 1;
                end
            end
        end else if (cn && m_credit > 0) begin
            m_chg = 1;
            e_rej = (c != 0);
        end else if (c != 0) begin
            if (cn) begin
                e_rej = 1;
            end else begin
                m_credit = m_credit + coin_tab[c];
                if (m_credit >= PRICE) begin
                    m_vend = 1;
                    e_z    = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic [1:0] c, input logic cn, input logic a);
        coin = c; cancel = cn; chg_ack = a;
        @(posedge clk);
        model_step(c, cn, a);
        #1;
        coin = 2'b00; cancel = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_checks++; if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=000", dut_vec()); end
        rst = 1'b1;
    endtask

    task automatic test_three_coins();
        tick(2'b01, 0, 0);
        n_checks++; if (credit !== 6'd5) begin n_fail++; $display("FAIL three_coins_c1 credit=%0d exp=5", credit); end
        tick(2'b01, 0, 0);
        n_checks++; if (credit !== 6'd10) begin n_fail++; $display("FAIL three_coins_c2 credit=%0d exp=10", credit); end
        tick(2'b01, 0, 0);
        n_checks++; if ({Z, busy, credit} !== {1'b1, 1'b1, 6'd15}) begin n_fail++; $display("FAIL three_coins_vend Z=%b busy=%b credit=%0d exp Z=1 busy=1 credit=15", Z, busy, credit); end
        tick(2'b00, 0, 0);
        n_checks++; if ({Z, busy, change_given, chg_req, credit} !== {4'b0000, 6'd0}) begin n_fail++; $display("FAIL three_coins_idle Z=%b busy=%b cg=%b req=%b credit=%0d exp all 0", Z, busy, change_given, chg_req, credit); end
    endtask

    task automatic test_overpay_change();
        tick(2'b11, 0, 0);
        n_checks++; if ({Z, credit} !== {1'b1, 6'd25}) begin n_fail++; $display("FAIL overpay_vend Z=%b credit=%0d exp Z=1 credit=25", Z, credit); end
        tick(2'b00, 0, 0);
        n_checks++; if ({Z, chg_req, credit} !== {1'b0, 1'b1, 6'd10}) begin n_fail++; $display("FAIL overpay_change Z=%b req=%b credit=%0d exp Z=0 req=1 credit=10", Z, chg_req, credit); end
        tick(2'b00, 0, 1);
        n_checks++; if ({chg_req, change_given, credit} !== {1'b1, 1'b0, 6'd5}) begin n_fail++; $display("FAIL overpay_ack1 req=%b cg=%b credit=%0d exp req=1 cg=0 credit=5", chg_req, change_given, credit); end
        tick(2'b00, 0, 1);
        n_checks++; if ({chg_req, change_given, busy, credit} !== {3'b010, 6'd0}) begin n_fail++; $display("FAIL overpay_done req=%b cg=%b busy=%b credit=%0d exp req=0 cg=1 busy=0 credit=0", chg_req, change_given, busy, credit); end
        tick(2'b00, 0, 0);
        n_checks++; if (change_given !== 1'b0) begin n_fail++; $display("FAIL overpay_cg_pulse cg=%b exp=0", change_given); end
    endtask

    task automatic test_two_dimes();
        tick(2'b10, 0, 0);
        tick(2'b10, 0, 0);
        n_checks++; if ({Z, credit} !== {1'b1, 6'd20}) begin n_fail++; $display("FAIL dimes_vend Z=%b credit=%0d exp Z=1 credit=20", Z, credit); end
        tick(2'b00, 0, 0);
        n_checks++; if ({chg_req, credit} !== {1'b1, 6'd5}) begin n_fail++; $display("FAIL dimes_change req=%b credit=%0d exp req=1 credit=5", chg_req, credit); end
        tick(2'b00, 0, 1);
        n_checks++; if ({change_given, chg_req} !== 2'b10) begin n_fail++; $display("FAIL dimes_done cg=%b req=%b exp cg=1 req=0", change_given, chg_req); end
    endtask

    task automatic test_cancel();
        tick(2'b01, 0, 0);
        tick(2'b00, 1, 0);
        n_checks++; if ({Z, chg_req, busy, credit} !== {3'b011, 6'd5}) begin n_fail++; $display("FAIL cancel_refund Z=%b req=%b busy=%b credit=%0d exp Z=0 req=1 busy=1 credit=5", Z, chg_req, busy, credit); end
        tick(2'b00, 0, 1);
        n_checks++; if ({change_given, credit} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL cancel_done cg=%b credit=%0d exp cg=1 credit=0", change_given, credit); end
        tick(2'b00, 1, 0);
        n_checks++; if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL cancel_idle got=%h exp=000", dut_vec()); end
    endtask

    task automatic test_reject_in_change();
        tick(2'b10, 0, 0);
        tick(2'b00, 1, 0);
        tick(2'b10, 0, 0);
        n_checks++; if ({coin_reject, chg_req, credit} !== {2'b11, 6'd10}) begin n_fail++; $display("FAIL reject_change rej=%b req=%b credit=%0d exp rej=1 req=1 credit=10", coin_reject, chg_req, credit); end
        for (int i = 0; i < 10; i++) begin
            tick(2'b00, 0, 0);
            n_checks++; if ({chg_req, coin_reject, credit} !== {2'b10, 6'd10}) begin n_fail++; $display("FAIL reject_hold cyc=%0d req=%b rej=%b credit=%0d exp req=1 rej=0 credit=10", i, chg_req, coin_reject, credit); end
        end
        tick(2'b00, 0, 1);
        tick(2'b00, 0, 1);
        n_checks++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL reject_drain got=%h exp=%h", dut_vec(), model_vec()); end
    endtask

    task automatic test_cancel_coin_and_async_reset();
        tick(2'b01, 0, 0);
        tick(2'b01, 1, 0);
        n_checks++; if ({coin_reject, chg_req, credit} !== {2'b11, 6'd5}) begin n_fail++; $display("FAIL cancel_coin rej=%b req=%b credit=%0d exp rej=1 req=1 credit=5", coin_reject, chg_req, credit); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL async_reset got=%h exp=000", dut_vec()); end
        model_reset();
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(2'b01, 0, 0);
            n_checks++; if (credit !== CW'(5 * i)) begin n_fail++; $display("FAIL post_reset_coin%0d credit=%0d exp=%0d", i, credit, 5 * i); end
        end
        n_checks++; if (Z !== 1'b1) begin n_fail++; $display("FAIL post_reset_vend Z=%b exp=1", Z); end
        tick(2'b00, 0, 0);
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic       cn, a;
        for (int i = 0; i < 600; i++) begin
            c  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cn = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 1) == 1);
            tick(c, cn, a);
            n_checks++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL random cyc=%0d in c=%0d cn=%b a=%b got=%h exp=%h", i, c, cn, a, dut_vec(), model_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_three_coins();
        test_overpay_change();
        test_two_dimes();
        test_cancel();
        test_reject_in_change();
        test_cancel_coin_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
